l2_line_fill: RTL and testbench

- Write-side engine for the L2 data and tag register arrays.
- Accepts a miss-fill request and issues a burst read to main memory.
- Assembles the returned beats into one full cache line.
- Writes that line into the register array in a single load cycle at the requested set index.
- Sits between the L2 control FSM (requester) and the array's load/index/datain write port.

---
 rtl/l2_types_pkg.sv | 18 +
 rtl/l2_fill_beat_buffer.sv | 31 +++
 rtl/l2_line_fill.sv | 70 +++++++
 tb/tb_l2_line_fill.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/l2_types_pkg.sv
// l2_types_pkg: fill-state encoding and line geometry shared by the L2 fill engine
package l2_types_pkg;
  typedef enum logic [1:0] {st_idle = 2'd0, st_read = 2'd1, st_write = 2'd2} fill_state_e;
  localparam int byte_bits = 8;
  localparam int def_beat_width = 64;
  localparam int def_num_beats = 4;
  localparam int def_line_width = def_beat_width * def_num_beats;
  localparam int def_line_off = $clog2(def_line_width / byte_bits);
  function automatic int beat_off_bits(input int nb);
    return $clog2(nb);
  endfunction
  function automatic int line_off_bits(input int bw, input int nb);
    return $clog2(nb * bw / byte_bits);
  endfunction
  function automatic int beat_byte_bits(input int bw);
    return $clog2(bw / byte_bits);
  endfunction
endpackage

// File: rtl/l2_fill_beat_buffer.sv
// l2_fill_beat_buffer: beat counter and slot buffer that assembles one line, wrapping from start_off
module l2_fill_beat_buffer import l2_types_pkg::*; #(
  parameter int beat_width = def_beat_width,
  parameter int num_beats = def_num_beats
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic [$clog2(num_beats)-1:0]    start_off,
  input  logic                            beat,
  input  logic [beat_width-1:0]           rdata,
  output logic                            last,
  output logic [beat_width*num_beats-1:0] line
);
  localparam int ow = beat_off_bits(num_beats);
  logic [ow-1:0] cnt;
  logic [ow-1:0] slot;
  assign slot = start_off + cnt;
  assign last = cnt == ow'(num_beats - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      line <= '0;
    end else if (clr) begin
      cnt <= '0;
      line <= '0;
    end else if (beat) begin
      line[slot*beat_width +: beat_width] <= rdata;
      cnt <= cnt + ow'(1);
    end
endmodule

// File: rtl/l2_line_fill.sv
// l2_line_fill: miss-fill engine (burst read, line assembly, single-cycle array write); L2_FILL_CRITICAL_WORD_FIRST_EN enables wrapped critical-word-first fills
module l2_line_fill import l2_types_pkg::*; #(
  parameter int s_index = 3,
  parameter int beat_width = def_beat_width,
  parameter int num_beats = def_num_beats,
  parameter int addr_width = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fill_req,
  input  logic [s_index-1:0]              fill_index,
  input  logic [addr_width-1:0]           fill_addr,
  output logic                            mem_read,
  output logic [addr_width-1:0]           mem_addr,
  input  logic                            mem_resp,
  input  logic [beat_width-1:0]           mem_rdata,
  output logic                            arr_load,
  output logic [s_index-1:0]              arr_index,
  output logic [beat_width*num_beats-1:0] arr_datain,
  output logic                            fill_done,
  output logic                            busy
);
  localparam int ow = beat_off_bits(num_beats);
`ifdef L2_FILL_CRITICAL_WORD_FIRST_EN
  localparam int keep = beat_byte_bits(beat_width);
  localparam int lb = line_off_bits(beat_width, num_beats);
`else
  localparam int keep = line_off_bits(beat_width, num_beats);
`endif
  localparam logic [addr_width-1:0] amask = ~((addr_width'(1) << keep) - addr_width'(1));
  fill_state_e state;
  logic [ow-1:0] off;
  logic start;
  logic beat;
  logic last;
  assign start = state == st_idle && fill_req;
  assign beat = state == st_read && mem_resp;
  assign mem_read = state == st_read;
  assign busy = state != st_idle;
  assign arr_load = state == st_write;
  assign fill_done = state == st_write;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= st_idle;
      mem_addr <= '0;
      arr_index <= '0;
      off <= '0;
    end else begin
      if (start) begin
        arr_index <= fill_index;
        mem_addr <= fill_addr & amask;
`ifdef L2_FILL_CRITICAL_WORD_FIRST_EN
        off <= fill_addr[lb-1:keep];
`else
        off <= '0;
`endif
      end
      state <= start ? st_read : (beat && last) ? st_write : state == st_write ? st_idle : state;
    end
  l2_fill_beat_buffer #(.beat_width(beat_width), .num_beats(num_beats)) u_buf (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .start_off(off),
    .beat(beat),
    .rdata(mem_rdata),
    .last(last),
    .line(arr_datain)
  );
endmodule

// File: tb/tb_l2_line_fill.sv
// tb_l2_line_fill: directed checks of the L2 line-fill engine
module tb_l2_line_fill;
  logic clk = 0, rst = 0, fill_req = 0, mem_resp = 0;
  logic [2:0] fill_index = 0;
  logic [31:0] fill_addr = 0;
  logic [63:0] mem_rdata = 0;
  logic mem_read, arr_load, fill_done, busy;
  logic [31:0] mem_addr;
  logic [2:0] arr_index;
  logic [255:0] arr_datain;
  int checks = 0, failures = 0, loads = 0;
`ifdef L2_FILL_CRITICAL_WORD_FIRST_EN
  localparam logic [31:0] exp_a1234 = 32'h1230;
  localparam logic [31:0] exp_a1230 = 32'h1230;
  localparam logic [31:0] exp_a2018 = 32'h2018;
  localparam logic [255:0] exp_abcd = {64'hB, 64'hA, 64'hD, 64'hC};
  localparam logic [255:0] exp_r = {64'h11, 64'h14, 64'h13, 64'h12};
`else
  localparam logic [31:0] exp_a1234 = 32'h1220;
  localparam logic [31:0] exp_a1230 = 32'h1220;
  localparam logic [31:0] exp_a2018 = 32'h2000;
  localparam logic [255:0] exp_abcd = {64'hD, 64'hC, 64'hB, 64'hA};
  localparam logic [255:0] exp_r = {64'h14, 64'h13, 64'h12, 64'h11};
`endif
  l2_line_fill dut (
    .clk(clk), .rst(rst), .fill_req(fill_req), .fill_index(fill_index), .fill_addr(fill_addr),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .arr_load(arr_load), .arr_index(arr_index), .arr_datain(arr_datain),
    .fill_done(fill_done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (arr_load) loads++;
  task automatic fill(input logic [2:0] idx, input logic [31:0] addr, input logic [63:0] b0, input int gap,
                      input bit poke, output int lat, output bit rd_ok, output logic [31:0] maddr);
    fill_req = 1; fill_index = idx; fill_addr = addr; lat = 0;
    @(negedge clk); lat++; fill_req = 0; maddr = mem_addr; rd_ok = mem_read && busy;
    @(negedge clk); lat++;
    for (int b = 0; b < 4; b++) begin
      if (b == 2)
        for (int g = 0; g < gap; g++) begin
          @(negedge clk); lat++; rd_ok &= mem_read;
        end
      if (poke) begin fill_req = b < 3; fill_index = 3'd2; end
      mem_resp = 1; mem_rdata = b0 + 64'(b);
      @(negedge clk); lat++; mem_resp = 0;
      if (b < 3) rd_ok &= mem_read;
    end
    fill_req = 0;
    for (int w = 0; w < 20 && !fill_done; w++) begin @(negedge clk); lat++; end
  endtask
  task automatic test_reset;
    @(negedge clk);
    checks++; if ({mem_read, arr_load, fill_done, busy} !== 4'b0) begin failures++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_read, arr_load, fill_done, busy}); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    checks++; if (arr_index !== 3'd0) begin failures++; $display("FAIL reset_index: got %0d expected 0", arr_index); end
    checks++; if (arr_datain !== 256'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", arr_datain); end
    rst = 1;
    @(negedge clk);
  endtask
  task automatic test_basic_fill;
    int lat, l0; bit rd_ok; logic [31:0] maddr;
    l0 = loads;
    fill(3'd5, 32'h0000_1234, 64'hA, 0, 0, lat, rd_ok, maddr);
    checks++; if (maddr !== exp_a1234) begin failures++; $display("FAIL basic_addr: got %h expected %h", maddr, exp_a1234); end
    checks++; if (rd_ok !== 1'b1) begin failures++; $display("FAIL basic_mem_read: got %b expected 1", rd_ok); end
    checks++; if (lat !== 6) begin failures++; $display("FAIL basic_latency: got %0d expected 6", lat); end
    checks++; if ({arr_load, fill_done} !== 2'b11) begin failures++; $display("FAIL basic_load: got %b expected 11", {arr_load, fill_done}); end
    checks++; if (arr_index !== 3'd5) begin failures++; $display("FAIL basic_index: got %0d expected 5", arr_index); end
    checks++; if (arr_datain !== exp_abcd) begin failures++; $display("FAIL basic_data: got %h expected %h", arr_datain, exp_abcd); end
    @(negedge clk);
    checks++; if ({arr_load, fill_done, busy} !== 3'b0) begin failures++; $display("FAIL basic_pulse: got %b expected 000", {arr_load, fill_done, busy}); end
    checks++; if (loads !== l0 + 1) begin failures++; $display("FAIL basic_load_count: got %0d expected %0d", loads, l0 + 1); end
  endtask
  task automatic test_gapped;
    int lat; bit rd_ok; logic [31:0] maddr;
    fill(3'd5, 32'h0000_1234, 64'hA, 3, 0, lat, rd_ok, maddr);
    checks++; if (rd_ok !== 1'b1) begin failures++; $display("FAIL gap_mem_read: got %b expected 1", rd_ok); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL gap_latency: got %0d expected 9", lat); end
    checks++; if (arr_datain !== exp_abcd) begin failures++; $display("FAIL gap_data: got %h expected %h", arr_datain, exp_abcd); end
    @(negedge clk);
  endtask
  task automatic test_ignored;
    int lat, l0; bit rd_ok; logic [31:0] maddr;
    mem_resp = 1; mem_rdata = 64'hFF;
    repeat (3) @(negedge clk);
    mem_resp = 0;
    checks++; if ({busy, mem_read, arr_load} !== 3'b0) begin failures++; $display("FAIL idle_resp_state: got %b expected 000", {busy, mem_read, arr_load}); end
    checks++; if (arr_datain !== exp_abcd) begin failures++; $display("FAIL idle_resp_data: got %h expected %h", arr_datain, exp_abcd); end
    l0 = loads;
    fill(3'd5, 32'h0000_1234, 64'hA, 0, 1, lat, rd_ok, maddr);
    checks++; if (lat !== 6) begin failures++; $display("FAIL ign_latency: got %0d expected 6", lat); end
    checks++; if (arr_index !== 3'd5) begin failures++; $display("FAIL ign_index: got %0d expected 5", arr_index); end
    checks++; if (arr_datain !== exp_abcd) begin failures++; $display("FAIL ign_data: got %h expected %h", arr_datain, exp_abcd); end
    repeat (10) @(negedge clk);
    checks++; if (loads !== l0 + 1) begin failures++; $display("FAIL ign_extra_fill: got %0d loads expected %0d", loads, l0 + 1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_busy: got %b expected 0", busy); end
  endtask
  task automatic test_async_reset;
    int lat, l0; bit rd_ok; logic [31:0] maddr;
    l0 = loads;
    fill_req = 1; fill_index = 3'd6; fill_addr = 32'h1234;
    @(negedge clk); fill_req = 0;
    @(negedge clk); mem_resp = 1; mem_rdata = 64'hA;
    @(negedge clk); mem_rdata = 64'hB;
    @(negedge clk); mem_resp = 0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
    #2 rst = 0;
    #1;
    checks++; if ({mem_read, busy, arr_load, fill_done} !== 4'b0) begin failures++; $display("FAIL rst_async_ctrl: got %b expected 0000", {mem_read, busy, arr_load, fill_done}); end
    checks++; if (arr_datain !== 256'h0) begin failures++; $display("FAIL rst_async_data: got %h expected 0", arr_datain); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_async_addr: got %h expected 0", mem_addr); end
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++; if (loads !== l0) begin failures++; $display("FAIL rst_no_load: got %0d loads expected %0d", loads, l0); end
    fill(3'd1, 32'h0000_2018, 64'h11, 0, 0, lat, rd_ok, maddr);
    checks++; if (maddr !== exp_a2018) begin failures++; $display("FAIL rst_next_addr: got %h expected %h", maddr, exp_a2018); end
    checks++; if (arr_index !== 3'd1) begin failures++; $display("FAIL rst_next_index: got %0d expected 1", arr_index); end
    checks++; if (arr_datain !== exp_r) begin failures++; $display("FAIL rst_next_data: got %h expected %h", arr_datain, exp_r); end
    checks++; if (lat !== 6) begin failures++; $display("FAIL rst_next_latency: got %0d expected 6", lat); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    int p, t1, t2; logic [2:0] i1, i2; logic [255:0] d2;
    p = 0; t1 = 0; t2 = 0; i1 = 0; i2 = 0; d2 = 0;
    fill_index = 3'd3; fill_addr = 32'h1234; mem_rdata = 64'hBB; mem_resp = 1; fill_req = 1;
    for (int c = 1; c <= 40 && p < 2; c++) begin
      @(negedge clk);
      if (busy) fill_index = 3'd4;
      if (arr_load) begin
        if (p == 0) begin t1 = c; i1 = arr_index; end
        else begin t2 = c; i2 = arr_index; d2 = arr_datain; fill_req = 0; mem_resp = 0; end
        p++;
      end
    end
    fill_req = 0; mem_resp = 0;
    checks++; if (p !== 2) begin failures++; $display("FAIL b2b_pulses: got %0d expected 2", p); end
    checks++; if (i1 !== 3'd3 || i2 !== 3'd4) begin failures++; $display("FAIL b2b_index: got %0d,%0d expected 3,4", i1, i2); end
    checks++; if (t1 !== 5) begin failures++; $display("FAIL b2b_first_time: got %0d expected 5", t1); end
    checks++; if (t2 - t1 !== 6) begin failures++; $display("FAIL b2b_spacing: got %0d expected 6", t2 - t1); end
    checks++; if (d2 !== {4{64'hBB}}) begin failures++; $display("FAIL b2b_data: got %h expected %h", d2, {4{64'hBB}}); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b expected 0", busy); end
  endtask
  task automatic test_critical_word;
    int lat; bit rd_ok; logic [31:0] maddr;
    fill(3'd7, 32'h0000_1230, 64'hA, 0, 0, lat, rd_ok, maddr);
    checks++; if (maddr !== exp_a1230) begin failures++; $display("FAIL cwf_addr: got %h expected %h", maddr, exp_a1230); end
    checks++; if (arr_datain !== exp_abcd) begin failures++; $display("FAIL cwf_data: got %h expected %h", arr_datain, exp_abcd); end
    checks++; if (arr_index !== 3'd7) begin failures++; $display("FAIL cwf_index: got %0d expected 7", arr_index); end
    @(negedge clk);
  endtask
  initial begin
    test_reset;
    test_basic_fill;
    test_gapped;
    test_ignored;
    test_async_reset;
    test_back_to_back;
    test_critical_word;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
